// File: rtl/hilo_unit.sv
// HI/LO special-register unit: 64-bit product capture, MTHI/MTLO, MADD/MSUB and a
// WIDTH-step restoring DIV/DIVU. Optional macro HILO_FWD_EN bypasses single-cycle writes onto Hi/Lo.
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Valid,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] ProdHi,
    input  logic [WIDTH-1:0] ProdLo,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             DivDone,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_WRITE64 = 3'd1;
    localparam logic [2:0] OP_MTHI    = 3'd2;
    localparam logic [2:0] OP_MTLO    = 3'd3;
    localparam logic [2:0] OP_MADD    = 3'd4;
    localparam logic [2:0] OP_MSUB    = 3'd5;
    localparam logic [2:0] OP_DIV     = 3'd6;
    localparam logic [2:0] OP_DIVU    = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_orig_q, dvd_orig_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             divz_q, divz_d;
    logic             done_q, done_d;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             trial_ok;

    assign a_neg     = (Op == OP_DIV) && A[WIDTH-1];
    assign b_neg     = (Op == OP_DIV) && B[WIDTH-1];
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvs_q};
    assign trial_ok  = ~trial[WIDTH];

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        dvd_orig_d = dvd_orig_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        divz_d     = divz_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Valid) begin
                    case (Op)
                        OP_WRITE64: {hi_d, lo_d} = {ProdHi, ProdLo};
                        OP_MTHI:    hi_d = A;
                        OP_MTLO:    lo_d = A;
                        OP_MADD:    {hi_d, lo_d} = {hi_q, lo_q} + {ProdHi, ProdLo};
                        OP_MSUB:    {hi_d, lo_d} = {hi_q, lo_q} - {ProdHi, ProdLo};
                        OP_DIV, OP_DIVU: begin
                            // quo register starts as the dividend magnitude and shifts out MSB-first
                            quo_d      = a_neg ? (~A + 1'b1) : A;
                            dvs_d      = b_neg ? (~B + 1'b1) : B;
                            rem_d      = '0;
                            dvd_orig_d = A;
                            qneg_d     = a_neg ^ b_neg;
                            rneg_d     = a_neg;
                            divz_d     = (B == '0);
                            cnt_d      = CW'(WIDTH);
                            state_d    = S_DIV;
                        end
                        default: ;
                    endcase
                end
            end
            S_DIV: begin
                rem_d = trial_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], trial_ok};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (divz_q) begin
                    lo_d = '1;
                    hi_d = dvd_orig_q;
                end else begin
                    lo_d = qneg_q ? (~quo_q + 1'b1) : quo_q;
                    hi_d = rneg_q ? (~rem_q + 1'b1) : rem_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            dvd_orig_q <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            divz_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            dvd_orig_q <= dvd_orig_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            divz_q     <= divz_d;
            done_q     <= done_d;
        end
    end

    assign Busy    = (state_q != S_IDLE);
    assign DivDone = done_q;

`ifdef HILO_FWD_EN
    // In IDLE the next-state value differs from the register only for an accepted single-cycle op
    assign Hi = (state_q == S_IDLE) ? hi_d : hi_q;
    assign Lo = (state_q == S_IDLE) ? lo_d : lo_q;
`else
    assign Hi = hi_q;
    assign Lo = lo_q;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: random single-cycle ops and divides against a
// behavioural model using 64-bit arithmetic and the language's own division operators.
module tb_hilo_unit;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        Valid;
    logic [2:0]  Op;
    logic [31:0] ProdHi, ProdLo, A, B;
    logic        Busy, DivDone;
    logic [31:0] Hi, Lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] hi_m, lo_m;

    hilo_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Valid(Valid), .Op(Op),
        .ProdHi(ProdHi), .ProdLo(ProdLo), .A(A), .B(B),
        .Busy(Busy), .DivDone(DivDone), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_single(input logic [2:0] op, input logic [31:0] a, ph, pl);
        logic [63:0] acc;
        acc = {hi_m, lo_m};
        case (op)
            3'd1: acc = {ph, pl};
            3'd2: acc[63:32] = a;
            3'd3: acc[31:0] = a;
            3'd4: acc = acc + {ph, pl};
            3'd5: acc = acc - {ph, pl};
            default: ;
        endcase
        {hi_m, lo_m} = acc;
    endtask

    task automatic model_div(input logic sgn, input logic [31:0] a, b,
                             output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, sq, sr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, ph, pl);
        @(negedge Clk);
        Valid = 1'b1; Op = op; A = a; ProdHi = ph; ProdLo = pl; B = $urandom;
        @(negedge Clk);
        Valid = 1'b0; Op = 3'd0;
        model_single(op, a, ph, pl);
    endtask

    // Runs one divide; optionally injects MTHI at busy cycle inj and/or issues MTLO fval in the DivDone cycle
    task automatic run_div(input logic [2:0] op, input logic [31:0] a, b, input int inj,
                           input logic follow, input logic [31:0] fval);
        logic [31:0] q, r;
        int cyc;
        logic held_bad;
        model_div(op == 3'd6, a, b, q, r);
        @(negedge Clk);
        Valid = 1'b1; Op = op; A = a; B = b;
        @(negedge Clk);
        Valid = 1'b0; Op = 3'd0;
        cyc = 0;
        held_bad = 1'b0;
        while (Busy && cyc < 100) begin
            cyc++;
            if (Hi !== hi_m || Lo !== lo_m) held_bad = 1'b1;
            A = $urandom; B = $urandom;
            if (cyc == inj) begin
                Valid = 1'b1; Op = 3'd2;
            end else begin
                Valid = 1'b0; Op = 3'd0;
            end
            @(negedge Clk);
        end
        Valid = 1'b0; Op = 3'd0;
        total++;
        if (cyc !== 33) begin
            bad++; $display("FAIL div_busy_len op=%0d a=%h b=%h got=%0d want=33", op, a, b, cyc);
        end
        total++;
        if (held_bad) begin
            bad++; $display("FAIL div_hold op=%0d a=%h b=%h Hi/Lo changed during divide want %h/%h", op, a, b, hi_m, lo_m);
        end
        total++;
        if (DivDone !== 1'b1) begin
            bad++; $display("FAIL div_done_pulse got=%b want=1", DivDone);
        end
        total++;
        if (Lo !== q) begin
            bad++; $display("FAIL div_quot op=%0d a=%h b=%h got=%h want=%h", op, a, b, Lo, q);
        end
        total++;
        if (Hi !== r) begin
            bad++; $display("FAIL div_rem op=%0d a=%h b=%h got=%h want=%h", op, a, b, Hi, r);
        end
        hi_m = r; lo_m = q;
        if (follow) begin
            Valid = 1'b1; Op = 3'd3; A = fval;
            model_single(3'd3, fval, 32'd0, 32'd0);
        end
        @(negedge Clk);
        Valid = 1'b0; Op = 3'd0;
        total++;
        if (DivDone !== 1'b0) begin
            bad++; $display("FAIL div_done_width got=%b want=0", DivDone);
        end
        if (follow) begin
            total++;
            if (Lo !== lo_m || Hi !== hi_m) begin
                bad++; $display("FAIL back_to_back got=%h_%h want=%h_%h", Hi, Lo, hi_m, lo_m);
            end
        end
        $display("div op=%0d a=%h b=%h -> Hi=%h Lo=%h busy=%0d", op, a, b, Hi, Lo, cyc);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Valid = 1'b0; Op = 3'd0; A = 0; B = 0; ProdHi = 0; ProdLo = 0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        hi_m = 0; lo_m = 0;
        total++; if (Hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", Hi); end
        total++; if (Lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", Lo); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
        total++; if (DivDone !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", DivDone); end
        $display("reset Hi=%h Lo=%h Busy=%b DivDone=%b", Hi, Lo, Busy, DivDone);
    endtask

    task automatic test_write_madd_msub();
        issue(3'd1, 32'd0, 32'h0000_0001, 32'h8000_0000);
        total++;
        if (Hi !== 32'h1 || Lo !== 32'h8000_0000) begin
            bad++; $display("FAIL write64 got=%h_%h want=00000001_80000000", Hi, Lo);
        end
        $display("write64 Hi=%h Lo=%h", Hi, Lo);
        issue(3'd4, 32'd0, 32'h0, 32'h8000_0000);
        total++;
        if (Hi !== 32'h2 || Lo !== 32'h0) begin
            bad++; $display("FAIL madd_carry got=%h_%h want=00000002_00000000", Hi, Lo);
        end
        $display("madd Hi=%h Lo=%h", Hi, Lo);
        issue(3'd5, 32'd0, 32'h0, 32'h8000_0000);
        total++;
        if (Hi !== 32'h1 || Lo !== 32'h8000_0000) begin
            bad++; $display("FAIL msub_borrow got=%h_%h want=00000001_80000000", Hi, Lo);
        end
        $display("msub Hi=%h Lo=%h", Hi, Lo);
    endtask

    task automatic test_random_single();
        logic [2:0] op;
        logic [31:0] a, ph, pl;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 5));
            a = $urandom; ph = $urandom; pl = $urandom;
            if (i % 7 == 0) begin
                ph = 32'hFFFF_FFFF; pl = 32'hFFFF_FFFF;
            end
            issue(op, a, ph, pl);
            total++;
            if (Hi !== hi_m || Lo !== lo_m) begin
                bad++; $display("FAIL single_op op=%0d got=%h_%h want=%h_%h", op, Hi, Lo, hi_m, lo_m);
            end
            $display("single op=%0d a=%h prod=%h_%h -> Hi=%h Lo=%h", op, a, ph, pl, Hi, Lo);
        end
    endtask

    task automatic test_div_directed();
        run_div(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 32'd0);
        total++;
        if (Lo !== 32'hFFFF_FFFD || Hi !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL div_neg7_by_2 got=%h_%h want=ffffffff_fffffffd", Hi, Lo);
        end
        run_div(3'd7, 32'd7, 32'd0, 0, 1'b0, 32'd0);
        total++;
        if (Lo !== 32'hFFFF_FFFF || Hi !== 32'd7) begin
            bad++; $display("FAIL divu_by_zero got=%h_%h want=00000007_ffffffff", Hi, Lo);
        end
        run_div(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'd0);
        total++;
        if (Lo !== 32'h8000_0000 || Hi !== 32'd0) begin
            bad++; $display("FAIL div_min_by_m1 got=%h_%h want=00000000_80000000", Hi, Lo);
        end
        run_div(3'd6, 32'hFFFF_FFF0, 32'd0, 0, 1'b0, 32'd0);
    endtask

    task automatic test_div_random();
        logic [2:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            op = ($urandom_range(0, 1) == 1) ? 3'd6 : 3'd7;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) b = $urandom;
            else b = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 2) == 0) b = -b;
            run_div(op, a, b, $urandom_range(0, 34), 1'b0, 32'd0);
        end
    endtask

    task automatic test_back_to_back();
        run_div(3'd7, 32'd100, 32'd7, 0, 1'b1, 32'hCAFE_0001);
        run_div(3'd6, 32'hFFFF_FF9C, 32'd7, 5, 1'b1, 32'h0BAD_F00D);
    endtask

    task automatic test_reset_mid_div();
        int cyc;
        int done_seen;
        @(negedge Clk);
        Valid = 1'b1; Op = 3'd6; A = 32'h1234_5678; B = 32'd3;
        @(negedge Clk);
        Valid = 1'b0; Op = 3'd0;
        cyc = 1;
        while (cyc < 15) begin
            @(negedge Clk);
            cyc++;
        end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        hi_m = 0; lo_m = 0;
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", Busy); end
        total++; if (Hi !== 32'd0 || Lo !== 32'd0) begin bad++; $display("FAIL abort_hilo got=%h_%h want=0_0", Hi, Lo); end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (DivDone !== 1'b0) done_seen++;
            @(negedge Clk);
        end
        total++; if (done_seen != 0) begin bad++; $display("FAIL abort_done got=%0d pulses want=0", done_seen); end
        issue(3'd3, 32'd5, 32'd0, 32'd0);
        total++;
        if (Lo !== 32'd5 || Hi !== 32'd0) begin
            bad++; $display("FAIL abort_then_mtlo got=%h_%h want=00000000_00000005", Hi, Lo);
        end
        $display("reset mid-divide -> Busy=%b Hi=%h Lo=%h", Busy, Hi, Lo);
    endtask

    task automatic test_fwd();
        logic [31:0] want_now;
        @(negedge Clk);
        Valid = 1'b1; Op = 3'd3; A = 32'h0000_1234;
`ifdef HILO_FWD_EN
        want_now = 32'h0000_1234;
`else
        want_now = lo_m;
`endif
        #1;
        total++;
        if (Lo !== want_now) begin
            bad++; $display("FAIL fwd_same_cycle got=%h want=%h", Lo, want_now);
        end
        @(negedge Clk);
        Valid = 1'b0; Op = 3'd0;
        model_single(3'd3, 32'h0000_1234, 32'd0, 32'd0);
        total++;
        if (Lo !== 32'h0000_1234) begin
            bad++; $display("FAIL fwd_next_cycle got=%h want=00001234", Lo);
        end
        $display("mtlo 0x1234 same-cycle Lo=%h next-cycle Lo=%h", want_now, Lo);
    endtask

    initial begin
        test_reset();
        test_write_madd_msub();
        test_random_single();
        test_div_directed();
        test_div_random();
        test_back_to_back();
        test_reset_mid_div();
        test_fwd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
